// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package mem_arbiter_pkg;

  localparam int AW_DEF      = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_FETCH = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERROR = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-port signals of the arbiter; names are from the arbiter's side.
interface mem_arbiter_if #(parameter int AW = 32) ();

  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [AW-1:0] if_rdata_o;
  logic          if_ack_o;

  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [AW-1:0] dm_wdata_i;
  logic [AW-1:0] dm_rdata_o;
  logic          dm_ack_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [AW-1:0] mem_wdata_o;
  logic [AW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  logic          stall_o;
  logic          err_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Wait-cycle counter for an outstanding memory access; hit_o flags the
// cycle whose missing ack would make the wait reach TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_inc[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_o = en_i && (cnt_inc == 9'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access;
// data has priority, one access in flight, sticky timeout error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  arb_state_e    state_q;
  logic          gnt_dm_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q, mem_wdata_q;
  logic          if_ack_q, dm_ack_q;
  logic [AW-1:0] if_rdata_q, dm_rdata_q;
  logic          err_q;
  logic          tmr_clr, tmr_en, tmr_hit;

  // Held clear while idle so every new access starts counting from zero.
  assign tmr_clr = (state_q == ST_IDLE);
  assign tmr_en  = mem_req_q & ~bus.mem_ack_i;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .hit_o (tmr_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      gnt_dm_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.dm_req_i) begin
            state_q     <= ST_DATA;
            gnt_dm_q    <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we_i;
            mem_addr_q  <= bus.dm_addr_i;
            mem_wdata_q <= bus.dm_wdata_i;
          end else if (bus.if_req_i) begin
            state_q     <= ST_FETCH;
            gnt_dm_q    <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        ST_DATA, ST_FETCH: begin
          // An ack in the timeout cycle still completes the access.
          if (bus.mem_ack_i) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            if (gnt_dm_q) begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= mem_we_q ? '0 : bus.mem_rdata_i;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata_i;
            end
          end else if (tmr_hit) begin
            state_q   <= ST_ERROR;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
          end
        end
        ST_RESP:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.err_o       = err_q;
  assign bus.stall_o     = (bus.dm_req_i & ~dm_ack_q) | (bus.if_req_i & ~if_ack_q) |
                           (state_q == ST_ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single accesses, a scoreboard of
// expected acks, and hand sequences for conflict, timeout and reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int TO = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        dm;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_dm = '0;
  bit          acked;
  bit          mem_en = 1'b0;
  bit          force_ack = 1'b0;
  int          mem_dly = 0;
  int          wcnt = 0;

  function automatic logic [31:0] mem_model(logic [31:0] a);
    return (a == 32'h4) ? 32'h8C22_0000 : ((a ^ 32'hC3A5_0F1E) + 32'd7);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory responder: acks after mem_dly wait cycles of an asserted mem_req_o.
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      bus.mem_ack_i = 1'b0;
      if (force_ack) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hBAD0_BAD0;
      end else if (mem_en && bus.mem_req_o === 1'b1) begin
        if (wcnt == mem_dly) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_model(bus.mem_addr_o);
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic idle_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;
  endtask

  // Advance to the next falling edge and settle any ack against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    acked = 1'b0;
    if (bus.if_ack_o || bus.dm_ack_o) begin
      acked = 1'b1;
      chk("single_ack", {31'd0, bus.if_ack_o & bus.dm_ack_o}, 32'd0);
      if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_side", {31'd0, bus.dm_ack_o}, {31'd0, e.dm});
        if (e.dm) begin
          chk("dm_rdata", bus.dm_rdata_o, e.rdata);
          last_dm = e.rdata;
        end else begin
          chk("if_rdata", bus.if_rdata_o, e.rdata);
          chk("dm_rdata_hold", bus.dm_rdata_o, last_dm);
        end
      end
    end
  endtask

  task automatic wait_mreq(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (bus.mem_req_o) ok = 1'b1;
    end
    if (!ok) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input string nm, input bit stall_free_at_ack);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (i > 0) tick();
      if (acked) begin
        ok = 1'b1;
        if (stall_free_at_ack) chk("stall_at_ack", {31'd0, bus.stall_o}, 32'd0);
      end else chk("stall_wait", {31'd0, bus.stall_o}, 32'd1);
    end
    if (!ok) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic access(input vec_t v);
    bit ok;
    @(posedge clk_i); #1;
    if (v.dm) begin
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = v.we;
      bus.dm_addr_i  = v.addr;
      bus.dm_wdata_i = v.wdata;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = v.addr;
    end
    sb.push_back('{dm: v.dm, rdata: v.exp_rdata});
    mem_dly = v.dly;
    mem_en  = 1'b1;
    wait_mreq("grant_timeout", ok);
    if (ok) begin
      chk("mem_addr", bus.mem_addr_o, v.addr);
      chk("mem_we", {31'd0, bus.mem_we_o}, {31'd0, v.dm & v.we});
      chk("mem_wdata", bus.mem_wdata_o, v.dm ? v.wdata : 32'd0);
      acked = 1'b0;
      wait_ack("ack_timeout", 1'b1);
    end
    #1 idle_inputs();
    tick();
    chk("idle_no_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("no_err", {31'd0, bus.err_o}, 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    idle_inputs();
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 2, 32'h8C22_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, mem_model(32'h30)};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 3, mem_model(32'h100)};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 3, mem_model(32'h44)};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 32'h0};

    rst_i = 1'b1;
    repeat (3) tick();
    chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_acks", {30'd0, bus.if_ack_o, bus.dm_ack_o}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 32'd0);
    chk("rst_err", {31'd0, bus.err_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) access(vecs[i]);

    // Simultaneous requests: data first, then the fetch.
    @(posedge clk_i); #1;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h10;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    sb.push_back('{dm: 1'b1, rdata: mem_model(32'h10)});
    sb.push_back('{dm: 1'b0, rdata: mem_model(32'h200)});
    mem_dly = 1; mem_en = 1'b1;
    wait_mreq("conf_grant0", ok);
    chk("conf_addr0", bus.mem_addr_o, 32'h10);
    acked = 1'b0;
    wait_ack("conf_ack0", 1'b0);
    #1 bus.dm_req_i = 1'b0;
    wait_mreq("conf_grant1", ok);
    chk("conf_addr1", bus.mem_addr_o, 32'h200);
    acked = 1'b0;
    wait_ack("conf_ack1", 1'b1);
    #1 idle_inputs();
    tick();

    // Timeout: no memory ack; late acks must be ignored.
    @(posedge clk_i); #1;
    mem_en = 1'b0;
    bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h40;
    wait_mreq("to_grant", ok);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.mem_req_o) break;
      n++;
    end
    chk("to_wait_cycles", n, TO);
    chk("to_err", {31'd0, bus.err_o}, 32'd1);
    chk("to_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("to_stall", {31'd0, bus.stall_o}, 32'd1);
    force_ack = 1'b1;
    repeat (2) tick();
    force_ack = 1'b0;
    bus.dm_req_i = 1'b0;
    repeat (2) tick();
    chk("to_err_sticky", {31'd0, bus.err_o}, 32'd1);
    chk("to_stall_err", {31'd0, bus.stall_o}, 32'd1);
    chk("to_no_ack", {30'd0, bus.if_ack_o, bus.dm_ack_o}, 32'd0);
    rst_i = 1'b1;
    #1 chk("err_cleared", {31'd0, bus.err_o}, 32'd0);
    chk("stall_cleared", {31'd0, bus.stall_o}, 32'd0);
    last_dm = '0;
    tick();
    rst_i = 1'b0;
    tick();

    // Reset during an outstanding fetch.
    @(posedge clk_i); #1;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
    wait_mreq("rst_mid_grant", ok);
    tick();
    #2 rst_i = 1'b1;
    #1 chk("rst_mid_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_mid_ack", {31'd0, bus.if_ack_o}, 32'd0);
    idle_inputs();
    last_dm = '0;
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    chk("rst_mid_idle", {31'd0, bus.mem_req_o}, 32'd0);
    access('{1'b0, 1'b0, 32'h300, 32'h0, 1, mem_model(32'h300)});

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles mem_req_o may wait for mem_ack_i (1..255).
REQ-002 Parameter AW, default 32: address and data width.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 if_req_i  in  1  fetch request, held until if_ack_o.
REQ-006 if_addr_i  in  AW  fetch address (PC).
REQ-007 if_rdata_o  out  AW  fetched instruction, valid when if_ack_o=1.
REQ-008 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req_i  in  1  data request, held until dm_ack_o.
REQ-010 dm_we_i  in  1  1 = store, 0 = load.
REQ-011 dm_addr_i  in  AW  data address (ALU result).
REQ-012 dm_wdata_i  in  AW  store data (RT value).
REQ-013 dm_rdata_o  out  AW  load data, valid when dm_ack_o=1.
REQ-014 dm_ack_o  out  1  one-cycle data completion pulse.
REQ-015 mem_req_o, mem_we_o  out  1 each  memory-port request and write enable.
REQ-016 mem_addr_o, mem_wdata_o  out  AW each  memory-port address and write data.
REQ-017 mem_rdata_i  in  AW; mem_ack_i  in  1  memory read data and one-cycle completion.
REQ-018 stall_o  out  1  freeze PC and IF/ID while any access is outstanding.
REQ-019 err_o  out  1  sticky timeout flag.

Function
REQ-020 The FSM SHALL have states IDLE, DATA, FETCH, RESP and ERROR.
REQ-021 IDLE: dm_req_i=1 SHALL go to DATA; otherwise if_req_i=1 SHALL go to FETCH. Data wins when both request in the same cycle.
REQ-022 On leaving IDLE, addr, we and wdata SHALL be latched. we SHALL be forced to 0 for FETCH.
REQ-023 mem_req_o SHALL be 1 exactly while in DATA or FETCH. mem_addr_o, mem_we_o and mem_wdata_o SHALL be driven from the latched values.
REQ-024 In DATA/FETCH, mem_ack_i=1 SHALL capture mem_rdata_i into the granted side's rdata register and go to RESP.
REQ-025 RESP SHALL pulse the granted side's ack for exactly one cycle and then go to IDLE.
REQ-026 No grant SHALL be made in RESP, so minimum access latency is 3 cycles (request, memory ack, response).
REQ-027 A request seen in IDLE after a RESP SHALL be treated as a new access.
REQ-028 mem_ack_i in IDLE, RESP or ERROR SHALL be ignored.
REQ-029 Stores SHALL return dm_rdata_o = 0.
REQ-030 A cycle counter SHALL clear on entry to DATA/FETCH and increment each cycle mem_ack_i=0.
REQ-031 When the counter reaches TIMEOUT, the FSM SHALL go to ERROR, set err_o and issue no ack.
REQ-032 If mem_ack_i=1 in the same cycle the counter reaches TIMEOUT, the ack SHALL win.
REQ-033 ERROR SHALL be absorbing until reset, with mem_req_o=0 and stall_o=1.
REQ-034 stall_o SHALL be combinational: (dm_req_i & ~dm_ack_o) | (if_req_i & ~if_ack_o) | (state==ERROR).
REQ-035 if_rdata_o and dm_rdata_o SHALL hold their value until the next capture.

Reset
REQ-036 rst_i=1 SHALL immediately force state IDLE, counter 0, and all of the following to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o, err_o.
REQ-037 Reset during an outstanding access SHALL drop mem_req_o asynchronously; no ack SHALL be produced for that access.

Structure
REQ-038 A shared package SHALL hold the state encoding (3-bit), the AW default and the TIMEOUT default.
REQ-039 The timeout counter SHALL be a sub-module, mem_arb_timer (clear, enable, hit outputs, 8-bit).

Verification
REQ-040 Fetch: if_req_i=1, if_addr_i=0x04; memory acks 2 cycles after mem_req_o with 0x8C220000 -> if_ack_o pulses once with if_rdata_o=0x8C220000; stall_o=1 until that cycle.
REQ-041 Conflict: dm_req_i and if_req_i rise together; dm_addr_i=0x10, load -> the data access is granted first and completes first, then the fetch; mem_addr_o sequence is 0x10 then the PC.
REQ-042 Store: dm_we_i=1, dm_wdata_i=0xDEADBEEF, addr 0x20 -> mem_we_o=1 and mem_wdata_o=0xDEADBEEF while mem_req_o; dm_rdata_o=0.
REQ-043 Timeout: TIMEOUT=4, mem_ack_i held 0 -> ERROR after 4 waiting cycles, err_o=1 sticky, mem_req_o=0, stall_o=1; late mem_ack_i is ignored.
REQ-044 Tie: TIMEOUT=4 and mem_ack_i arrives on the 4th wait cycle -> normal ack, err_o stays 0.
REQ-045 Reset mid-access: rst_i pulsed while mem_req_o=1 -> mem_req_o=0 in the same cycle, no ack; a later request completes normally.
